// File: rtl/spi_sram_responder.sv
// SPI mode-0 subordinate emulating a sequential-mode serial SRAM on a small internal byte array.
// SPI pins are oversampled on clk_i; read/write/mode commands run over a single-clock FSM.
module spi_sram_responder #(
    parameter int          MemBytes = 256,
    parameter logic [7:0]  ModeRst  = 8'h40,
    localparam int         AW       = $clog2(MemBytes)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          spi_clk_i,
    input  logic          cs_n_i,
    input  logic          mosi_i,
    output logic          miso_o,
    output logic          miso_oe_o,
    output logic          busy_o,
    output logic          cmd_err_o,
    input  logic [AW-1:0] dbg_addr_i,
    output logic [7:0]    dbg_rdata_o
);

    // Shift register holds one bit less than the widest field; the newest bit comes straight from mosi_i.
    localparam int RW = ((AW > 8) ? AW : 8) - 1;

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, WDATA, RDATA, MODE_WR, MODE_RD, IGNORE
    } state_t;

    state_t        state_reg;
    logic          sck_reg;
    logic          armed_reg;
    logic [RW-1:0] shin_reg;
    logic [4:0]    bit_cnt_reg;
    logic [7:0]    out_reg;
    logic [3:0]    out_cnt_reg;
    logic [AW-1:0] addr_reg;
    logic          op_write_reg;
    logic [7:0]    mode_reg;
    logic          wr_pend_reg;
    logic [7:0]    wr_byte_reg;
    logic          miso_reg;
    logic          oe_reg;
    logic          busy_reg;
    logic          cmd_err_reg;

    logic [7:0]    mem [MemBytes];

    logic          rise;
    logic          fall;
    logic [RW:0]   shin_full;
    logic [7:0]    rx_byte;
    logic [AW-1:0] rx_addr;
    logic [AW-1:0] addr_inc;
    logic [7:0]    rd_byte;
    logic [7:0]    rd_byte_inc;

    assign rise        = spi_clk_i & ~sck_reg;
    assign fall        = ~spi_clk_i & sck_reg;
    assign shin_full   = {shin_reg, mosi_i};
    assign rx_byte     = shin_full[7:0];
    assign rx_addr     = shin_full[AW-1:0];
    assign addr_inc    = addr_reg + AW'(1);
    assign rd_byte     = mem[addr_reg];
    assign rd_byte_inc = mem[addr_inc];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            sck_reg      <= 1'b0;
            armed_reg    <= 1'b0;
            shin_reg     <= '0;
            bit_cnt_reg  <= 5'd0;
            out_reg      <= 8'h00;
            out_cnt_reg  <= 4'd0;
            addr_reg     <= '0;
            op_write_reg <= 1'b0;
            mode_reg     <= ModeRst;
            wr_pend_reg  <= 1'b0;
            wr_byte_reg  <= 8'h00;
            miso_reg     <= 1'b0;
            oe_reg       <= 1'b0;
            busy_reg     <= 1'b0;
            cmd_err_reg  <= 1'b0;
        end else begin
            sck_reg     <= spi_clk_i;
            busy_reg    <= ~cs_n_i;
            cmd_err_reg <= 1'b0;
            wr_pend_reg <= 1'b0;
            // A transfer already in progress when reset releases is skipped until CS goes high.
            if (cs_n_i) begin
                armed_reg <= 1'b1;
            end
            if (wr_pend_reg) begin
                addr_reg <= addr_inc;
            end

            if (cs_n_i) begin
                state_reg   <= IDLE;
                bit_cnt_reg <= 5'd0;
                miso_reg    <= 1'b0;
                oe_reg      <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (armed_reg) begin
                            state_reg   <= CMD;
                            bit_cnt_reg <= rise ? 5'd1 : 5'd0;
                            if (rise) begin
                                shin_reg <= shin_full[RW-1:0];
                            end
                        end
                    end

                    CMD: begin
                        if (rise) begin
                            shin_reg <= shin_full[RW-1:0];
                            if (bit_cnt_reg == 5'd7) begin
                                bit_cnt_reg <= 5'd0;
                                case (rx_byte)
                                    8'h02: begin
                                        state_reg    <= ADDR;
                                        op_write_reg <= 1'b1;
                                    end
                                    8'h03: begin
                                        state_reg    <= ADDR;
                                        op_write_reg <= 1'b0;
                                    end
                                    8'h01: state_reg <= MODE_WR;
                                    8'h05: begin
                                        state_reg   <= MODE_RD;
                                        oe_reg      <= 1'b1;
                                        out_cnt_reg <= 4'd0;
                                    end
                                    default: begin
                                        state_reg   <= IGNORE;
                                        cmd_err_reg <= 1'b1;
                                    end
                                endcase
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 5'd1;
                            end
                        end
                    end

                    ADDR: begin
                        if (rise) begin
                            shin_reg <= shin_full[RW-1:0];
                            if (bit_cnt_reg == 5'd23) begin
                                bit_cnt_reg <= 5'd0;
                                addr_reg    <= rx_addr;
                                if (op_write_reg) begin
                                    state_reg <= WDATA;
                                end else begin
                                    state_reg   <= RDATA;
                                    oe_reg      <= 1'b1;
                                    out_cnt_reg <= 4'd0;
                                end
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 5'd1;
                            end
                        end
                    end

                    WDATA: begin
                        if (rise) begin
                            shin_reg <= shin_full[RW-1:0];
                            if (bit_cnt_reg == 5'd7) begin
                                bit_cnt_reg <= 5'd0;
                                wr_pend_reg <= 1'b1;
                                wr_byte_reg <= rx_byte;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 5'd1;
                            end
                        end
                    end

                    // out_cnt_reg counts bits already driven from the current byte; 0 means none loaded yet.
                    RDATA: begin
                        if (fall) begin
                            if (out_cnt_reg == 4'd0) begin
                                miso_reg    <= rd_byte[7];
                                out_reg     <= {rd_byte[6:0], 1'b0};
                                out_cnt_reg <= 4'd1;
                            end else if (out_cnt_reg == 4'd8) begin
                                miso_reg    <= rd_byte_inc[7];
                                out_reg     <= {rd_byte_inc[6:0], 1'b0};
                                addr_reg    <= addr_inc;
                                out_cnt_reg <= 4'd1;
                            end else begin
                                miso_reg    <= out_reg[7];
                                out_reg     <= {out_reg[6:0], 1'b0};
                                out_cnt_reg <= out_cnt_reg + 4'd1;
                            end
                        end
                    end

                    MODE_RD: begin
                        if (fall) begin
                            if (out_cnt_reg == 4'd0 || out_cnt_reg == 4'd8) begin
                                miso_reg    <= mode_reg[7];
                                out_reg     <= {mode_reg[6:0], 1'b0};
                                out_cnt_reg <= 4'd1;
                            end else begin
                                miso_reg    <= out_reg[7];
                                out_reg     <= {out_reg[6:0], 1'b0};
                                out_cnt_reg <= out_cnt_reg + 4'd1;
                            end
                        end
                    end

                    MODE_WR: begin
                        if (rise && bit_cnt_reg != 5'd8) begin
                            shin_reg    <= shin_full[RW-1:0];
                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                            if (bit_cnt_reg == 5'd7) begin
                                mode_reg <= rx_byte;
                            end
                        end
                    end

                    IGNORE: ;
                endcase
            end
        end
    end

    // Memory has no reset so its contents survive a reset pulse.
    always_ff @(posedge clk_i) begin
        if (wr_pend_reg) begin
            mem[addr_reg] <= wr_byte_reg;
        end
    end

    assign miso_o      = miso_reg;
    assign miso_oe_o   = oe_reg;
    assign busy_o      = busy_reg;
    assign cmd_err_o   = cmd_err_reg;
    assign dbg_rdata_o = mem[dbg_addr_i];

endmodule
